// File: rtl/cpu_mem_pkg.sv
// Shared widths and types for the data-memory request path of the 8-bit CPU.
package cpu_mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int RD_W   = 3;

    // One store-buffer slot; valid marks a committed store not yet written to memory.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    // IDLE accepts requests; LWAIT waits for the data of a load that missed the store buffer.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        LWAIT = 1'b1
    } mau_state_e;

endpackage

// File: rtl/store_buffer.sv
// Circular FIFO of committed stores with a parallel youngest-match lookup port.
module store_buffer
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push_i,
    input  logic [ADDR_W-1:0]            push_addr_i,
    input  logic [DATA_W-1:0]            push_data_i,
    input  logic                         pop_i,
    output logic [ADDR_W-1:0]            head_addr_o,
    output logic [DATA_W-1:0]            head_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    input  logic [ADDR_W-1:0]            lk_addr_i,
    output logic                         lk_hit_o,
    output logic [DATA_W-1:0]            lk_data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_entry_t        slot_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    // Push at the tail, pop at the head; popping clears valid so lookups skip drained slots.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop_i) begin
                slot_q[head_q].valid <= 1'b0;
                head_q               <= head_q + 1'b1;
            end
            if (push_i) begin
                slot_q[tail_q] <= '{valid: 1'b1, addr: push_addr_i, data: push_data_i};
                tail_q         <= tail_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Scan oldest to youngest so the last match left standing is the youngest store.
    always_comb begin
        lk_hit_o  = 1'b0;
        lk_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_q[head_q + PTR_W'(i)].valid &&
                slot_q[head_q + PTR_W'(i)].addr == lk_addr_i) begin
                lk_hit_o  = 1'b1;
                lk_data_o = slot_q[head_q + PTR_W'(i)].data;
            end
        end
    end

    assign head_addr_o = slot_q[head_q].addr;
    assign head_data_o = slot_q[head_q].data;
    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;

endmodule

// File: rtl/mem_access_unit.sv
// Request side of the data-memory port: load/store acceptance, store buffering,
// store-to-load forwarding, write draining and tagged load writeback.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready never looks at req_valid; the requester keeps its fields stable until then.
module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int SB_DEPTH = 4,
    parameter int READ_LAT = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_store,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic [DATA_W-1:0]               req_wdata,
    input  logic [RD_W-1:0]                 req_rd,
    input  logic                            flush,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic [DATA_W-1:0]               mem_rdata,
    output logic                            wb_valid,
    output logic [DATA_W-1:0]               wb_data,
    output logic [RD_W-1:0]                 wb_rd,
    output logic [$clog2(SB_DEPTH+1)-1:0]   sb_count,
    output mau_state_e                      dbg_state
);

    localparam int LAT_W = $clog2(READ_LAT + 1);

    mau_state_e        state_q;
    logic [LAT_W-1:0]  lat_q;
    logic              squash_q;
    logic              fwd_q;
    logic [RD_W-1:0]   pend_rd_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              wb_valid_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [RD_W-1:0]   wb_rd_q;

    logic              sb_full;
    logic              sb_empty;
    logic              lk_hit;
    logic [DATA_W-1:0] lk_data;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              accept;
    logic              ld_hit;
    logic              ld_miss;
    logic              sb_push;
    logic              sb_pop;

    store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (sb_push),
        .push_addr_i (req_addr),
        .push_data_i (req_wdata),
        .pop_i       (sb_pop),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .full_o      (sb_full),
        .empty_o     (sb_empty),
        .count_o     (sb_count),
        .lk_addr_i   (req_addr),
        .lk_hit_o    (lk_hit),
        .lk_data_o   (lk_data)
    );

    assign req_ready = (state_q == IDLE) && !flush && !sb_full;
    assign accept    = req_valid && req_ready;
    assign ld_hit    = accept && !req_store && lk_hit;
    assign ld_miss   = accept && !req_store && !lk_hit;
    assign sb_push   = accept && req_store;
    // A missing load owns the port for its read cycle; otherwise the oldest store drains.
    assign sb_pop    = !ld_miss && !sb_empty;

    // FSM, read-latency counter, squash flag, port arbiter and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            squash_q    <= 1'b0;
            fwd_q       <= 1'b0;
            pend_rd_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
        end else begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            fwd_q       <= 1'b0;
            if (ld_miss) begin
                mem_read_q <= 1'b1;
                mem_addr_q <= req_addr;
            end else if (sb_pop) begin
                mem_write_q <= 1'b1;
                mem_addr_q  <= head_addr;
                mem_wdata_q <= head_data;
            end
            case (state_q)
                IDLE: begin
                    if (ld_miss) begin
                        state_q   <= LWAIT;
                        lat_q     <= LAT_W'(READ_LAT);
                        squash_q  <= 1'b0;
                        pend_rd_q <= req_rd;
                    end else if (ld_hit) begin
                        wb_valid_q <= 1'b1;
                        fwd_q      <= 1'b1;
                        wb_data_q  <= lk_data;
                        wb_rd_q    <= req_rd;
                    end
                end
                LWAIT: begin
                    if (lat_q == '0) begin
                        // mem_rdata is valid now; a flush this cycle still squashes it.
                        state_q  <= IDLE;
                        squash_q <= 1'b0;
                        if (!(squash_q || flush)) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= mem_rdata;
                            wb_rd_q    <= pend_rd_q;
                        end
                    end else begin
                        lat_q <= lat_q - 1'b1;
                        if (flush) begin
                            squash_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A forwarded result cannot know about a flush in its own cycle, so gate the pulse here.
    assign wb_valid  = wb_valid_q && !(fwd_q && flush);
    assign wb_data   = wb_data_q;
    assign wb_rd     = wb_rd_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model of the store buffer and load
// timing, a behavioural data memory, and directed scenarios with literal checks.
module tb_mem_access_unit;
    import cpu_mem_pkg::*;

    localparam int SB_DEPTH = 4;
    localparam int READ_LAT = 2;

    logic       clk;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_store;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic [2:0] req_rd;
    logic       flush;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       wb_valid;
    logic [7:0] wb_data;
    logic [2:0] wb_rd;
    logic [2:0] sb_count;
    mau_state_e dbg_state;

    mem_access_unit #(.SB_DEPTH(SB_DEPTH), .READ_LAT(READ_LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_store (req_store),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rd    (req_rd),
        .flush     (flush),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .wb_rd     (wb_rd),
        .sb_count  (sb_count),
        .dbg_state (dbg_state)
    );

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded 20000 time units");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural data memory ----------------
    logic [7:0] mem [256];
    int         rd_due = -100;
    logic [7:0] rd_val = 8'h00;

    always @(negedge clk) begin
        if (mem_write) mem[mem_addr] = mem_wdata;
        if (mem_read) begin
            rd_due = cyc + READ_LAT;
            rd_val = mem[mem_addr];
        end
    end

    always @(posedge clk) begin
        #1;
        mem_rdata = (cyc == rd_due) ? rd_val : 8'hEE;
    end

    // ---------------- reference model + compare ----------------
    // exp_q holds {addr,data} of stores still buffered, oldest first.
    logic [15:0] exp_q[$];
    logic [7:0]  model_mem [256];
    int          rd_cyc = -1, wr_cyc = -1, wb_cyc = -1, ld_acc = -1, ld_ret = -1;
    logic [7:0]  rd_addr_e, wr_addr_e, wr_data_e, wb_data_e;
    logic [2:0]  wb_rd_e;
    bit          wb_kill, wb_fwd, busy, exp_ready, wbv, miss, found;
    logic [7:0]  fdata;
    logic [15:0] ent;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            rd_cyc = -1; wr_cyc = -1; wb_cyc = -1; ld_acc = -1; ld_ret = -1;
            wb_kill = 1'b0; wb_fwd = 1'b0;
            chk("rst_mem_read", mem_read, 0);
            chk("rst_mem_write", mem_write, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_wb_valid", wb_valid, 0);
            chk("rst_wb_data", wb_data, 0);
            chk("rst_wb_rd", wb_rd, 0);
            chk("rst_sb_count", sb_count, 0);
        end else begin
            busy      = (ld_ret > cyc);
            exp_ready = !busy && !flush && (exp_q.size() != SB_DEPTH);
            chk("req_ready", req_ready, exp_ready);
            chk("state_lwait", dbg_state == LWAIT, busy);
            chk("sb_count", sb_count, exp_q.size());
            chk("mem_read", mem_read, rd_cyc == cyc);
            if (rd_cyc == cyc) chk("mem_read_addr", mem_addr, rd_addr_e);
            chk("mem_write", mem_write, wr_cyc == cyc);
            if (wr_cyc == cyc) begin
                chk("mem_write_addr", mem_addr, wr_addr_e);
                chk("mem_write_data", mem_wdata, wr_data_e);
            end
            wbv = (wb_cyc == cyc) && !wb_kill && !(wb_fwd && flush);
            chk("wb_valid", wb_valid, wbv);
            if (wbv) begin
                chk("wb_data", wb_data, wb_data_e);
                chk("wb_rd", wb_rd, wb_rd_e);
            end
            // A flush from the read cycle through the data cycle squashes the miss.
            if (flush && busy && cyc > ld_acc) wb_kill = 1'b1;

            miss = 1'b0;
            if (req_valid && exp_ready && !req_store) begin
                found = 1'b0;
                fdata = 8'h00;
                for (int i = exp_q.size() - 1; i >= 0; i--) begin
                    if (!found && exp_q[i][15:8] == req_addr) begin
                        found = 1'b1;
                        fdata = exp_q[i][7:0];
                    end
                end
                wb_kill = 1'b0;
                wb_rd_e = req_rd;
                if (found) begin
                    wb_cyc = cyc + 1; wb_fwd = 1'b1; wb_data_e = fdata;
                end else begin
                    miss = 1'b1;
                    rd_cyc = cyc + 1; rd_addr_e = req_addr;
                    ld_acc = cyc; ld_ret = cyc + 2 + READ_LAT;
                    wb_cyc = ld_ret; wb_fwd = 1'b0; wb_data_e = model_mem[req_addr];
                end
            end
            if (!miss && exp_q.size() > 0) begin
                ent = exp_q.pop_front();
                wr_cyc = cyc + 1; wr_addr_e = ent[15:8]; wr_data_e = ent[7:0];
                model_mem[ent[15:8]] = ent[7:0];
            end
            if (req_valid && exp_ready && req_store) exp_q.push_back({req_addr, req_wdata});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic st, input logic [7:0] a, input logic [7:0] d, input logic [2:0] rd);
        bit done = 1'b0;
        req_valid = 1'b1; req_store = st; req_addr = a; req_wdata = d; req_rd = rd;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (req_ready) done = 1'b1;
        end
        n_vec++;
        if (!done) begin
            n_mis++;
            $display("FAIL send_timeout: req_ready stayed 0 for addr %0h, required 1", a);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        mem[a] = d;
        model_mem[a] = d;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            model_mem[i] = 8'h00;
        end
        preload(8'h10, 8'hA5);
        preload(8'h40, 8'h5C);
        preload(8'h44, 8'h3C);
        req_valid = 1'b0; req_store = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        req_rd = 3'd0; flush = 1'b0; mem_rdata = 8'h00;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Load miss: read one cycle after accept, result READ_LAT+2 after accept.
        send(1'b0, 8'h10, 8'h00, 3'd3);
        @(negedge clk);
        chk("lit_miss_read", mem_read, 1);
        chk("lit_miss_addr", mem_addr, 8'h10);
        repeat (3) @(negedge clk);
        chk("lit_miss_wbv", wb_valid, 1);
        chk("lit_miss_data", wb_data, 8'hA5);
        chk("lit_miss_rd", wb_rd, 3);
        idle(1);

        // Store then load of the same address is forwarded.
        send(1'b1, 8'h20, 8'h11, 3'd0);
        send(1'b0, 8'h20, 8'h00, 3'd5);
        @(negedge clk);
        chk("lit_fwd_wbv", wb_valid, 1);
        chk("lit_fwd_data", wb_data, 8'h11);
        chk("lit_fwd_rd", wb_rd, 5);
        chk("lit_fwd_noread", mem_read, 0);
        idle(3);

        // Youngest matching store wins.
        send(1'b1, 8'h30, 8'h01, 3'd0);
        send(1'b1, 8'h30, 8'h02, 3'd0);
        send(1'b0, 8'h30, 8'h00, 3'd1);
        @(negedge clk);
        chk("lit_young_data", wb_data, 8'h02);
        idle(3);

        // Stores queued behind a load miss drain in order.
        send(1'b0, 8'h10, 8'h00, 3'd7);
        for (int i = 0; i < 5; i++) send(1'b1, 8'(8'h80 + i), 8'(8'hC0 + i), 3'd0);
        idle(8);

        // Flush during LWAIT squashes the writeback; FSM returns on time.
        send(1'b0, 8'h40, 8'h00, 3'd2);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("lit_flush_ready", req_ready, 1);
        chk("lit_flush_nowb", wb_valid, 0);
        @(posedge clk); #1;
        send(1'b0, 8'h10, 8'h00, 3'd6);
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("lit_after_flush_wbv", wb_valid, 1);
        chk("lit_after_flush_data", wb_data, 8'hA5);
        idle(2);

        // Flush in the cycle a forwarded result would appear.
        send(1'b1, 8'h60, 8'h77, 3'd0);
        send(1'b0, 8'h60, 8'h00, 3'd4);
        flush = 1'b1;
        @(negedge clk);
        chk("lit_fwd_flush_nowb", wb_valid, 0);
        @(posedge clk); #1 flush = 1'b0;
        idle(3);

        // Reset while LWAIT with a store still buffered: the store is lost.
        send(1'b1, 8'h70, 8'h33, 3'd0);
        send(1'b0, 8'h44, 8'h00, 3'd1);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("lit_rst_ready", req_ready, 1);
        chk("lit_rst_count", sb_count, 0);
        chk("lit_rst_wbv", wb_valid, 0);
        @(posedge clk); #1;
        send(1'b0, 8'h44, 8'h00, 3'd1);
        idle(6);

        // Final memory image from drained stores.
        chk("mem_20", mem[8'h20], 8'h11);
        chk("mem_30", mem[8'h30], 8'h02);
        chk("mem_60", mem[8'h60], 8'h77);
        chk("mem_70", mem[8'h70], 8'h00);
        for (int i = 0; i < 5; i++) chk("mem_8x", mem[8'h80 + i], 8'hC0 + i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
